// File: rtl/seq_adder_bcd_pkg.sv
// Shared types and constants for the sequential adder / BCD display path.
// FSM encoding, segment table and elaboration-time sizing helpers.
package seq_adder_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} for decimal 0..9
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic bit bcd_fits(input int digits, input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p > (64'd1 << n);
    endfunction

endpackage

// File: rtl/seq_adder_bcd_if.sv
// Request/result bundle between the switch/key side and the adder.
// master drives the operands and start; slave returns status and result.
interface seq_adder_bcd_if #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
);
    localparam int N = WIDTH + 1;

    logic                  start;
    logic                  sub;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  busy;
    logic                  done;
    logic                  neg;
    logic [N-1:0]          bin;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output start, sub, a, b,
        input  busy, done, neg, bin, bcd, seg
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, neg, bin, bcd, seg
    );

endinterface

// File: rtl/dd_digit_step.sv
// One double-dabble correction: add 3 to a BCD digit of 5 or more
// so the following left shift carries correctly into the next digit.
module dd_digit_step (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/hex_7seg.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Decimal digits come from the shared table; A-F keep the usual glyphs.
module hex_7seg
    import seq_adder_bcd_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_hex <= 4'd9) begin
            o_seg = SEG_DIGIT[i_hex];
        end else begin
            case (i_hex)
                4'hA:    o_seg = 7'h08;
                4'hB:    o_seg = 7'h03;
                4'hC:    o_seg = 7'h46;
                4'hD:    o_seg = 7'h21;
                4'hE:    o_seg = 7'h06;
                default: o_seg = 7'h0E;
            endcase
        end
    end

endmodule

// File: rtl/seq_adder_bcd.sv
// Sequential add/subtract with iterative binary-to-BCD conversion
// and per-digit active-low 7-segment drive with leading-zero blanking.
module seq_adder_bcd
    import seq_adder_bcd_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic           CLOCK_50,
    input  logic           RST_N,
    seq_adder_bcd_if.slave bus
);

    localparam int N  = WIDTH + 1;
    localparam int BW = 4 * DIGITS;
    localparam int CW = clog2(N + 1);

    if (!bcd_fits(DIGITS, N)) begin : g_bad_digits
        $error("seq_adder_bcd: DIGITS too small for WIDTH");
    end

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic [N-1:0]       r_work_bin;
    logic [BW-1:0]      r_work_bcd;
    logic [CW-1:0]      r_cnt;
    logic [N-1:0]       r_mag;
    logic               r_neg_w;
    logic               r_busy;
    logic               r_done;
    logic               r_neg;
    logic [N-1:0]       r_bin;
    logic [BW-1:0]      r_bcd;

    logic [N-1:0]       w_sum;
    logic [N-1:0]       w_diff;
    logic [N-1:0]       w_mag;
    logic               w_a_ge_b;
    logic               w_neg;
    logic [BW-1:0]      w_adj;
    logic [BW+N-1:0]    w_shift;
    logic [7*DIGITS-1:0] w_seg;

    assign w_a_ge_b = (r_a >= r_b);
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff   = w_a_ge_b ? ({1'b0, r_a} - {1'b0, r_b})
                               : ({1'b0, r_b} - {1'b0, r_a});
    assign w_mag    = r_sub ? w_diff : w_sum;
    // Zero magnitude is always reported positive
    assign w_neg    = r_sub & ~w_a_ge_b & (|w_mag);

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dd
        dd_digit_step u_step (
            .i_digit (r_work_bcd[4*gi +: 4]),
            .o_digit (w_adj[4*gi +: 4])
        );
    end

    assign w_shift = {w_adj, r_work_bin} << 1;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_work_bin <= '0;
            r_work_bcd <= '0;
            r_cnt      <= '0;
            r_mag      <= '0;
            r_neg_w    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_neg      <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_sub   <= bus.sub;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_work_bin <= w_mag;
                    r_work_bcd <= '0;
                    r_mag      <= w_mag;
                    r_neg_w    <= w_neg;
                    r_cnt      <= CW'(N);
                    r_state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_work_bcd <= w_shift[BW+N-1:N];
                    r_work_bin <= w_shift[N-1:0];
                    r_cnt      <= r_cnt - CW'(1);
                    // Publish the final step directly so done and data align
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_shift[BW+N-1:N];
                        r_bin   <= r_mag;
                        r_neg   <= r_neg_w;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
        logic [6:0] w_hex;
        hex_7seg u_hex (
            .i_hex (r_bcd[4*gi +: 4]),
            .o_seg (w_hex)
        );
        if (gi == 0) begin : g_d0
            assign w_seg[6:0] = w_hex;
        end else begin : g_dn
            logic w_lz;
            assign w_lz = BLANK_LZ && (r_bcd[BW-1:4*gi] == '0);
            assign w_seg[7*gi +: 7] = w_lz ? SEG_BLANK : w_hex;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.neg  = r_neg;
    assign bus.bin  = r_bin;
    assign bus.bcd  = r_bcd;
    assign bus.seg  = w_seg;

endmodule

// File: tb/tb_seq_adder_bcd.sv
// Directed bench for seq_adder_bcd: 7-bit/3-digit and 10-bit/4-digit
// instances, checking latency, results, blanking, busy handling and reset.
module tb_seq_adder_bcd;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    seq_adder_bcd_if #(.WIDTH(7),  .DIGITS(3)) bus8 ();
    seq_adder_bcd_if #(.WIDTH(10), .DIGITS(4)) bus11 ();

    seq_adder_bcd #(.WIDTH(7), .DIGITS(3), .BLANK_LZ(1'b1)) u_dut8 (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (bus8)
    );

    seq_adder_bcd #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1'b1)) u_dut11 (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (bus11)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic run8(input int a, input int b, input bit s, output int lat);
        @(negedge clk);
        bus8.a = 7'(a);
        bus8.b = 7'(b);
        bus8.sub = s;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (bus8.done === 1'b1) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run11(input int a, input int b, input bit s, output int lat);
        @(negedge clk);
        bus11.a = 10'(a);
        bus11.b = 10'(b);
        bus11.sub = s;
        bus11.start = 1'b1;
        @(negedge clk);
        bus11.start = 1'b0;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (bus11.done === 1'b1) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_total++;
        if (bus8.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus8.busy);
        else n_pass++;
        n_total++;
        if (bus8.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus8.done);
        else n_pass++;
        n_total++;
        if (bus8.neg !== 1'b0) $display("FAIL rst_neg: got %b want 0", bus8.neg);
        else n_pass++;
        n_total++;
        if (bus8.bin !== 8'd0) $display("FAIL rst_bin: got %0h want 0", bus8.bin);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h000) $display("FAIL rst_bcd: got %0h want 0", bus8.bcd);
        else n_pass++;
        n_total++;
        if (bus8.seg !== {7'h7F, 7'h7F, 7'h40})
            $display("FAIL rst_seg8: got %0h want %0h", bus8.seg, {7'h7F, 7'h7F, 7'h40});
        else n_pass++;
        n_total++;
        if (bus11.seg !== {7'h7F, 7'h7F, 7'h7F, 7'h40})
            $display("FAIL rst_seg11: got %0h want %0h", bus11.seg,
                     {7'h7F, 7'h7F, 7'h7F, 7'h40});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        run8(100, 27, 1'b0, lat);
        n_total++;
        if (lat !== 9) $display("FAIL add_latency: got %0d want 9", lat);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h127) $display("FAIL add_bcd: got %0h want 127", bus8.bcd);
        else n_pass++;
        n_total++;
        if (bus8.bin !== 8'd127) $display("FAIL add_bin: got %0d want 127", bus8.bin);
        else n_pass++;
        n_total++;
        if (bus8.neg !== 1'b0) $display("FAIL add_neg: got %b want 0", bus8.neg);
        else n_pass++;
        n_total++;
        if (bus8.seg !== {7'h79, 7'h24, 7'h78})
            $display("FAIL add_seg: got %0h want %0h", bus8.seg, {7'h79, 7'h24, 7'h78});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus8.done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", bus8.done);
        else n_pass++;
        n_total++;
        if (bus8.busy !== 1'b0) $display("FAIL add_idle_busy: got %b want 0", bus8.busy);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h127) $display("FAIL add_hold: got %0h want 127", bus8.bcd);
        else n_pass++;
    endtask

    task automatic test_sub;
        int lat;
        run8(5, 90, 1'b1, lat);
        n_total++;
        if (lat !== 9) $display("FAIL sub_latency: got %0d want 9", lat);
        else n_pass++;
        n_total++;
        if (bus8.neg !== 1'b1) $display("FAIL sub_neg: got %b want 1", bus8.neg);
        else n_pass++;
        n_total++;
        if (bus8.bin !== 8'd85) $display("FAIL sub_bin: got %0d want 85", bus8.bin);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h085) $display("FAIL sub_bcd: got %0h want 085", bus8.bcd);
        else n_pass++;
        n_total++;
        if (bus8.seg !== {7'h7F, 7'h00, 7'h12})
            $display("FAIL sub_seg: got %0h want %0h", bus8.seg, {7'h7F, 7'h00, 7'h12});
        else n_pass++;
    endtask

    task automatic test_extremes;
        int lat;
        run8(127, 127, 1'b0, lat);
        n_total++;
        if (bus8.bcd !== 12'h254) $display("FAIL max_add_bcd: got %0h want 254", bus8.bcd);
        else n_pass++;
        n_total++;
        if (bus8.bin !== 8'd254) $display("FAIL max_add_bin: got %0d want 254", bus8.bin);
        else n_pass++;
        run8(0, 127, 1'b1, lat);
        n_total++;
        if (bus8.neg !== 1'b1) $display("FAIL min_sub_neg: got %b want 1", bus8.neg);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h127) $display("FAIL min_sub_bcd: got %0h want 127", bus8.bcd);
        else n_pass++;
        run8(0, 0, 1'b1, lat);
        n_total++;
        if (bus8.neg !== 1'b0) $display("FAIL zero_neg: got %b want 0", bus8.neg);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h000) $display("FAIL zero_bcd: got %0h want 0", bus8.bcd);
        else n_pass++;
        n_total++;
        if (bus8.seg !== {7'h7F, 7'h7F, 7'h40})
            $display("FAIL zero_seg: got %0h want %0h", bus8.seg, {7'h7F, 7'h7F, 7'h40});
        else n_pass++;
        run8(100, 5, 1'b0, lat);
        n_total++;
        if (bus8.seg !== {7'h79, 7'h40, 7'h12})
            $display("FAIL midzero_seg: got %0h want %0h", bus8.seg, {7'h79, 7'h40, 7'h12});
        else n_pass++;
        run8(10, 3, 1'b1, lat);
        n_total++;
        if (bus8.seg !== {7'h7F, 7'h7F, 7'h78})
            $display("FAIL onedig_seg: got %0h want %0h", bus8.seg, {7'h7F, 7'h7F, 7'h78});
        else n_pass++;
        n_total++;
        if (bus8.neg !== 1'b0) $display("FAIL onedig_neg: got %b want 0", bus8.neg);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        int busy_n;
        int done_n;
        bit found;
        run8(3, 4, 1'b0, lat);
        @(negedge clk);
        bus8.a = 7'd20;
        bus8.b = 7'd30;
        bus8.sub = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int j = 0; j < 20; j++) begin
            if (bus8.busy === 1'b1) busy_n++;
            if (bus8.done === 1'b1) done_n++;
            if (j == 4) begin
                n_total++;
                if (bus8.bin !== 8'd7) $display("FAIL b2b_held_bin: got %0d want 7", bus8.bin);
                else n_pass++;
            end
            if (j == 3) begin
                bus8.start = 1'b1;
                bus8.a = 7'd99;
            end
            if (j == 5) bus8.start = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (busy_n !== 10) $display("FAIL b2b_busy_cycles: got %0d want 10", busy_n);
        else n_pass++;
        n_total++;
        if (done_n !== 1) $display("FAIL b2b_done_count: got %0d want 1", done_n);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h050) $display("FAIL b2b_bcd: got %0h want 050", bus8.bcd);
        else n_pass++;
        bus8.a = 7'd1;
        bus8.b = 7'd2;
        bus8.start = 1'b1;
        found = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found) $display("FAIL retrig_first_done: got timeout want done");
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus8.busy !== 1'b0) $display("FAIL retrig_idle: got %b want 0", bus8.busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus8.busy !== 1'b1) $display("FAIL retrig_busy: got %b want 1", bus8.busy);
        else n_pass++;
        bus8.start = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_total++;
        if (!found || bus8.bin !== 8'd3)
            $display("FAIL retrig_result: got %0d (found=%0b) want 3", bus8.bin, found);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat;
        int done_n;
        @(negedge clk);
        bus8.a = 7'd50;
        bus8.b = 7'd60;
        bus8.sub = 1'b0;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if (bus8.busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", bus8.busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (bus8.busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", bus8.busy);
        else n_pass++;
        n_total++;
        if (bus8.bin !== 8'd0) $display("FAIL rmid_bin: got %0d want 0", bus8.bin);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h000) $display("FAIL rmid_bcd: got %0h want 0", bus8.bcd);
        else n_pass++;
        done_n = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) done_n++;
        end
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) done_n++;
        end
        n_total++;
        if (done_n !== 0) $display("FAIL rmid_no_done: got %0d want 0", done_n);
        else n_pass++;
        run8(50, 60, 1'b0, lat);
        n_total++;
        if (lat !== 9) $display("FAIL rmid_latency: got %0d want 9", lat);
        else n_pass++;
        n_total++;
        if (bus8.bcd !== 12'h110) $display("FAIL rmid_bcd_after: got %0h want 110", bus8.bcd);
        else n_pass++;
    endtask

    task automatic test_wide;
        int          va   [7] = '{1023, 0,    1000, 512,  7, 300, 999};
        int          vb   [7] = '{1023, 1023, 1,    488,  7, 845, 9};
        bit          vs   [7] = '{0,    1,    1,    0,    1, 1,   0};
        bit          vneg [7] = '{0,    1,    0,    0,    0, 1,   0};
        int          vbin [7] = '{2046, 1023, 999,  1000, 0, 545, 1008};
        logic [15:0] vbcd [7] = '{16'h2046, 16'h1023, 16'h0999, 16'h1000,
                                  16'h0000, 16'h0545, 16'h1008};
        int lat;
        for (int i = 0; i < 7; i++) begin
            run11(va[i], vb[i], vs[i], lat);
            n_total++;
            if (lat !== 12) $display("FAIL wide_latency[%0d]: got %0d want 12", i, lat);
            else n_pass++;
            n_total++;
            if (bus11.neg !== vneg[i])
                $display("FAIL wide_neg[%0d]: got %b want %b", i, bus11.neg, vneg[i]);
            else n_pass++;
            n_total++;
            if (bus11.bin !== 11'(vbin[i]))
                $display("FAIL wide_bin[%0d]: got %0d want %0d", i, bus11.bin, vbin[i]);
            else n_pass++;
            n_total++;
            if (bus11.bcd !== vbcd[i])
                $display("FAIL wide_bcd[%0d]: got %0h want %0h", i, bus11.bcd, vbcd[i]);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (bus11.done !== 1'b0)
                $display("FAIL wide_done_pulse[%0d]: got %b want 0", i, bus11.done);
            else n_pass++;
        end
        n_total++;
        if (bus11.seg !== {7'h79, 7'h40, 7'h40, 7'h00})
            $display("FAIL wide_seg: got %0h want %0h", bus11.seg,
                     {7'h79, 7'h40, 7'h40, 7'h00});
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0;
        bus8.sub = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus11.start = 1'b0;
        bus11.sub = 1'b0;
        bus11.a = '0;
        bus11.b = '0;
        test_reset();
        test_add();
        test_sub();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
